// File: rtl/sample_serializer.sv
// Sample-strobe consumer: periodic request timer, one-entry holding
// register and MSB-first 3-wire serializer toward an external DAC.
module sample_serializer #(
   parameter int N_FRAC    = 7,
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic [DIV_WIDTH-1:0] period_i,
   input  logic [N_FRAC:0]      data_i,
   input  logic                 data_in_valid_strobe_i,
   output logic                 next_data_strobe_o,
   output logic                 cs_n_o,
   output logic                 sclk_o,
   output logic                 sdata_o,
   output logic                 busy_o,
   output logic                 overrun_o
);

   localparam int W  = N_FRAC + 1;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      GAP
   } state_t;

   state_t               state;
   state_t               state_n;
   logic [DIV_WIDTH-1:0] count;
   logic [W-1:0]         hold;
   logic [W-1:0]         hold_n;
   logic                 hold_full;
   logic                 hold_full_n;
   logic [W-1:0]         shreg;
   logic [W-1:0]         shreg_n;
   logic [CW-1:0]        bitcnt;
   logic [CW-1:0]        bitcnt_n;
   logic                 take;
   logic                 capture;
   logic                 drop;
   logic                 shifting_n;

   // >= rather than == so a shrinking period never lets the count wrap
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count              <= '0;
         next_data_strobe_o <= 1'b0;
      end else if (!enable_i) begin
         count              <= '0;
         next_data_strobe_o <= 1'b0;
      end else if (count >= period_i) begin
         count              <= '0;
         next_data_strobe_o <= 1'b1;
      end else begin
         count              <= count + 1'b1;
         next_data_strobe_o <= 1'b0;
      end
   end

   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      bitcnt_n = bitcnt;
      take     = 1'b0;
      unique case (state)
         IDLE: begin
            if (hold_full) begin
               take     = 1'b1;
               shreg_n  = hold;
               bitcnt_n = CW'(W - 1);
               state_n  = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            state_n = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (bitcnt == '0) begin
               state_n = GAP;
            end else begin
               shreg_n  = {shreg[W-2:0], 1'b0};
               bitcnt_n = bitcnt - 1'b1;
               state_n  = SHIFT_LO;
            end
         end
         GAP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // A strobe landing while IDLE drains the hold still gets captured
   always_comb begin
      capture     = data_in_valid_strobe_i & (~hold_full | take);
      drop        = data_in_valid_strobe_i & hold_full & ~take;
      hold_full_n = capture | (hold_full & ~take);
      hold_n      = capture ? data_i : hold;
      shifting_n  = (state_n == SHIFT_LO) | (state_n == SHIFT_HI);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         shreg     <= '0;
         bitcnt    <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         bitcnt    <= bitcnt_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
      end
   end

   // Outputs registered from next-state so they line up with the state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cs_n_o    <= 1'b1;
         sclk_o    <= 1'b0;
         sdata_o   <= 1'b0;
         busy_o    <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         cs_n_o    <= ~shifting_n;
         sclk_o    <= (state_n == SHIFT_HI);
         sdata_o   <= shifting_n & shreg_n[W-1];
         busy_o    <= (state_n != IDLE) | hold_full_n;
         overrun_o <= overrun_o | drop;
      end
   end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer: timer table, frame table,
// closed loop with a sawtooth producer, overrun and reset corners.
module tb_sample_serializer;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       enable_i = 1'b0;
   logic [7:0] period_i = '0;
   logic [7:0] data_i = '0;
   logic       data_in_valid_strobe_i = 1'b0;
   logic       next_data_strobe_o;
   logic       cs_n_o;
   logic       sclk_o;
   logic       sdata_o;
   logic       busy_o;
   logic       overrun_o;

   sample_serializer #(.N_FRAC(7), .DIV_WIDTH(8)) dut (
      .clk_i                  (clk_i),
      .rst_i                  (rst_i),
      .enable_i               (enable_i),
      .period_i               (period_i),
      .data_i                 (data_i),
      .data_in_valid_strobe_i (data_in_valid_strobe_i),
      .next_data_strobe_o     (next_data_strobe_o),
      .cs_n_o                 (cs_n_o),
      .sclk_o                 (sclk_o),
      .sdata_o                (sdata_o),
      .busy_o                 (busy_o),
      .overrun_o              (overrun_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] data;
      logic [7:0] bits;
   } frame_vec_t;

   typedef struct {
      logic [7:0] period;
      logic       en;
      int         window;
      int         strobes;
   } timer_vec_t;

   int         ncmp = 0;
   int         nbad = 0;
   int         frames_done = 0;
   int         sample_cnt = 0;
   logic       mon_en = 1'b0;
   logic       check_words = 1'b1;
   logic       prod_en = 1'b0;
   logic [7:0] acc = '0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Serial receiver: collects bits on sclk rising, checks each frame
   int         low_cnt = 0;
   int         nbits = 0;
   logic [7:0] word = '0;
   logic       cs_q = 1'b1;
   logic       sclk_q = 1'b0;

   always @(negedge clk_i) begin
      if (!cs_n_o) begin
         low_cnt++;
         if (sclk_o && !sclk_q) begin
            word = {word[6:0], sdata_o};
            nbits++;
         end
      end else if (!cs_q) begin
         if (mon_en) begin
            check("frame_bits", nbits, 8);
            check("frame_len", low_cnt, 16);
            if (check_words) begin
               if (exp_q.size() == 0)
                  check("frame_unexpected", 1, 0);
               else
                  check("frame_word", word, exp_q.pop_front());
            end
            frames_done++;
         end
         nbits = 0;
         low_cnt = 0;
         word = '0;
      end
      cs_q = cs_n_o;
      sclk_q = sclk_o;
   end

   // Sawtooth producer 0,10,..,100,0,.. answering each request
   always @(negedge clk_i) begin
      if (prod_en) begin
         data_in_valid_strobe_i = next_data_strobe_o;
         if (next_data_strobe_o) begin
            data_i = acc;
            exp_q.push_back(acc);
            sample_cnt++;
            acc = (acc >= 8'd100) ? 8'd0 : acc + 8'd10;
         end
      end
   end

   task automatic do_reset();
      mon_en = 1'b0;
      prod_en = 1'b0;
      data_in_valid_strobe_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_q.delete();
      acc = '0;
      sample_cnt = 0;
      @(negedge clk_i);
      mon_en = 1'b1;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int target;
      target = frames_done + n;
      for (int i = 0; i < budget && frames_done < target; i++) begin
         @(negedge clk_i);
         #1;
      end
      check("frame_timeout", frames_done >= target, 1);
   endtask

   task automatic wait_strobe(input int budget, output int k);
      k = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i);
         k++;
         if (next_data_strobe_o) return;
      end
      k = -1;
   endtask

   frame_vec_t fv[5];
   timer_vec_t tv[5];

   initial begin
      int k;
      int cnt;
      fv[0] = '{8'hA5, 8'b1010_0101};
      fv[1] = '{8'h80, 8'b1000_0000};
      fv[2] = '{8'h7F, 8'b0111_1111};
      fv[3] = '{8'h01, 8'b0000_0001};
      fv[4] = '{8'hC3, 8'b1100_0011};
      tv[0] = '{8'd19, 1'b1, 100, 5};
      tv[1] = '{8'd0,  1'b1, 20, 20};
      tv[2] = '{8'd4,  1'b1, 50, 10};
      tv[3] = '{8'd7,  1'b1, 45, 5};
      tv[4] = '{8'd7,  1'b0, 40, 0};

      do_reset();
      check("rst_cs_n", cs_n_o, 1);
      check("rst_sclk", sclk_o, 0);
      check("rst_sdata", sdata_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_overrun", overrun_o, 0);
      check("rst_strobe", next_data_strobe_o, 0);

      // Frame table: latency, framing and bit order
      for (int r = 0; r < 5; r++) begin
         exp_q.push_back(fv[r].bits);
         @(negedge clk_i);
         data_i = fv[r].data;
         data_in_valid_strobe_i = 1'b1;
         @(negedge clk_i);
         data_in_valid_strobe_i = 1'b0;
         check("lat_cs_hi", cs_n_o, 1);
         check("lat_busy", busy_o, 1);
         @(negedge clk_i);
         check("lat_cs_lo", cs_n_o, 0);
         wait_frames(1, 60);
         @(negedge clk_i);
         check("busy_idle", busy_o, 0);
      end

      // Timer table
      for (int r = 0; r < 5; r++) begin
         do_reset();
         period_i = tv[r].period;
         enable_i = tv[r].en;
         cnt = 0;
         for (int i = 0; i < tv[r].window; i++) begin
            @(negedge clk_i);
            if (next_data_strobe_o) cnt++;
         end
         check("timer_count", cnt, tv[r].strobes);
      end

      // Timer cadence and mid-run period reduction
      do_reset();
      period_i = 8'd19;
      enable_i = 1'b1;
      wait_strobe(40, k);
      check("tmr_first", k > 0, 1);
      wait_strobe(40, k);
      check("tmr_int20a", k, 20);
      wait_strobe(40, k);
      check("tmr_int20b", k, 20);
      repeat (10) @(negedge clk_i);
      period_i = 8'd4;
      @(negedge clk_i);
      check("tmr_shrink", next_data_strobe_o, 1);
      wait_strobe(40, k);
      check("tmr_int5a", k, 5);
      wait_strobe(40, k);
      check("tmr_int5b", k, 5);
      enable_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_i);
         if (next_data_strobe_o) cnt++;
      end
      check("tmr_disabled", cnt, 0);

      // Strobe in the very cycle IDLE drains the hold
      do_reset();
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h96);
      @(negedge clk_i);
      data_i = 8'h5A;
      data_in_valid_strobe_i = 1'b1;
      @(negedge clk_i);
      data_i = 8'h96;
      @(negedge clk_i);
      data_in_valid_strobe_i = 1'b0;
      wait_frames(2, 100);
      check("simul_overrun", overrun_o, 0);
      check("simul_queue", exp_q.size(), 0);

      // Closed loop at matched cadence
      do_reset();
      period_i = 8'd17;
      enable_i = 1'b1;
      prod_en = 1'b1;
      wait_frames(50, 50 * 18 + 200);
      check("loop_overrun", overrun_o, 0);

      // Overrun: third sample lands while the hold is full
      do_reset();
      check_words = 1'b0;
      period_i = 8'd3;
      enable_i = 1'b1;
      prod_en = 1'b1;
      for (int i = 0; i < 40 && sample_cnt < 2; i++) begin
         @(negedge clk_i);
         #1;
      end
      @(negedge clk_i);
      check("ovr_second_ok", overrun_o, 0);
      for (int i = 0; i < 40 && sample_cnt < 3; i++) begin
         @(negedge clk_i);
         #1;
      end
      @(negedge clk_i);
      check("ovr_third_set", overrun_o, 1);
      wait_frames(8, 250);
      check("ovr_sticky", overrun_o, 1);

      // Reset during the 5th bit of a frame
      for (int i = 0; i < 40 && !cs_n_o; i++) @(negedge clk_i);
      for (int i = 0; i < 40 && cs_n_o; i++) @(negedge clk_i);
      check("mid_frame_found", cs_n_o, 0);
      mon_en = 1'b0;
      repeat (8) @(negedge clk_i);
      prod_en = 1'b0;
      enable_i = 1'b0;
      data_in_valid_strobe_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("mrst_cs_n", cs_n_o, 1);
      check("mrst_sclk", sclk_o, 0);
      check("mrst_busy", busy_o, 0);
      check("mrst_overrun", overrun_o, 0);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         if (sclk_o || !cs_n_o) cnt++;
      end
      check("mrst_quiet", cnt, 0);
      exp_q.delete();
      check_words = 1'b1;
      mon_en = 1'b1;
      exp_q.push_back(8'h3C);
      @(negedge clk_i);
      data_i = 8'h3C;
      data_in_valid_strobe_i = 1'b1;
      @(negedge clk_i);
      data_in_valid_strobe_i = 1'b0;
      wait_frames(1, 60);
      check("mrst_resume_ovr", overrun_o, 0);

      $display("test done: total=%0d bad=%0d", ncmp, nbad);
      $finish;
   end

endmodule

// File: doc/sample_serializer.md
Name: sample_serializer

Overview:
Consumer end of the sample-strobe interface. The block issues periodic next-data requests to a sample producer such as the waveform counter. It captures each returned sample on the producer's valid strobe and shifts it out MSB-first on a 3-wire serial link (cs_n, sclk, sdata) toward an external DAC. A one-entry holding register decouples the request timing from the serial framing.

Parameters:
N_FRAC, 7, fractional bits; sample width W = N_FRAC+1
DIV_WIDTH, 8, width of sample-period register

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
enable_i  input  1  enables the request timer
period_i  input  DIV_WIDTH  sample period minus one, in clk_i cycles
data_i  input  W  signed sample from producer
data_in_valid_strobe_i  input  1  one-cycle pulse: data_i valid
next_data_strobe_o  output  1  one-cycle request pulse to producer
cs_n_o  output  1  frame select, active-low
sclk_o  output  1  serial clock, clk_i/2 during frame
sdata_o  output  1  serial data, MSB first
busy_o  output  1  frame in progress or holding register full
overrun_o  output  1  sticky: a sample was dropped

Behaviour:
- Reset (rst_i=1 at posedge):
  - Applies identically mid-frame or mid-period; the frame is aborted and no partial bits follow.
  - timer=0, hold empty, state IDLE, shift register 0.
  - next_data_strobe_o=0, cs_n_o=1, sclk_o=0, sdata_o=0, busy_o=0, overrun_o=0.
- All outputs are registered.
- Request timer:
  - enable_i=1: the count increments each cycle.
  - When count >= period_i, next_data_strobe_o pulses high for 1 cycle and the count reloads to 0. The strobe therefore repeats every period_i+1 cycles.
  - The >= compare handles a mid-run reduction of period_i without wrap.
  - period_i=0 gives a strobe every cycle.
  - enable_i=0: the count is held at 0, no strobes are issued, and an in-flight frame and hold drain still complete.
- Capture:
  - On data_in_valid_strobe_i=1, if hold is empty (or is emptied by the FSM in the same cycle), data_i is loaded and hold is marked full.
  - If hold is full and is not being emptied that cycle, the sample is dropped and overrun_o is set. overrun_o stays set until reset.
- Serializer FSM, states IDLE, SHIFT_LO, SHIFT_HI, GAP:
  - IDLE: if hold full, load the shift register from hold, clear hold full, and go to SHIFT_LO with bit count W-1. cs_n_o=0 from the next cycle.
  - SHIFT_LO: sclk_o=0, sdata_o = shift register MSB. Go to SHIFT_HI.
  - SHIFT_HI: sclk_o=1, sdata_o held. If bit count = 0, go to GAP; otherwise shift left by 1, decrement the count, and go to SHIFT_LO.
  - GAP: cs_n_o=1, sclk_o=0, sdata_o=0 for 1 cycle, then IDLE.
- Timing:
  - cs_n_o is low for exactly 2W cycles with W rising sclk edges.
  - The DAC samples sdata on the sclk rising edge; data is stable for a full clk_i cycle before and after each edge.
  - Frame cadence is 2W+2 cycles including IDLE and GAP (18 for W=8).
  - Latency: sample capture to first cs_n_o low is 2 cycles when the FSM is idle.
- Sustained throughput without overrun requires period_i+1 >= 2W+2.
- Data is transmitted as the raw two's-complement bit pattern; there is no width conversion.
- busy_o = (state != IDLE) | hold_full.

Test Plan:
- Single sample:
  - Stimulus: reset, then data_i=8'hA5 with one valid strobe.
  - Required: after 2 cycles cs_n_o low for 16 cycles; the sdata_o bits sampled on sclk_o rising edges read 1,0,1,0,0,1,0,1; GAP cycle with cs_n_o high; busy_o falls back to 0.
- Timer:
  - Stimulus: enable_i=1, period_i=19.
  - Required: next_data_strobe_o pulses exactly every 20 cycles.
  - Stimulus: change period_i to 4 while the count is 10.
  - Required: strobe on the next cycle, then every 5 cycles.
  - Stimulus: enable_i=0.
  - Required: no strobes.
- Closed loop with waveform counter:
  - Stimulus: period_i=17, producer amplitude 100, addend 10.
  - Required: serialized words 0,10,20,... in order, overrun_o stays 0 over 50 frames.
- Overrun:
  - Stimulus: period_i=3 with the producer in loop.
  - Required: overrun_o rises on the first sample arriving while hold is full and stays 1. Transmitted frames stay well-formed with 16 sclk phases each.
- Simultaneous:
  - Stimulus: a valid strobe in the same cycle the FSM empties hold in IDLE.
  - Required: no overrun, and the new sample is the next frame.
- Reset mid-frame:
  - Stimulus: assert rst_i at the 5th bit.
  - Required: next cycle cs_n_o=1, sclk_o=0, busy_o=0, overrun_o=0, and no further sclk edges until a new sample arrives.
